exec_stage: RTL and testbench

//  Parametrised EX stage for the RISC-V datapath. It holds the ID/EX pipeline register and
//  the ALU, and adds three things the earlier stage did not have: operand forwarding,

---
 rtl/exec_pkg.sv | 45 ++++
 rtl/exec_stage_if.sv | 43 ++++
 rtl/exec_alu.sv | 59 +++++
 rtl/exec_stage.sv | 141 ++++++++++++++
 tb/tb_exec_stage.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared types for the EX stage: control bundle layout, ALU operation classes and functions.
package exec_pkg;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_SUB  = 2'd1,
      ALU_FUNC = 2'd2,
      ALU_IMM  = 2'd3
   } alu_op_e;

   typedef enum logic [3:0] {
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
      FN_SLL, FN_SRL, FN_SRA, FN_SLT, FN_SLTU
   } alu_fn_e;

   // Bit 0 is alu_src, bit 8 is mul.
   typedef struct packed {
      logic    mul;
      logic    reg_wr;
      logic    mem2reg;
      logic    mem_wr;
      logic    mem_rd;
      logic    branch;
      alu_op_e alu_op;
      logic    alu_src;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   localparam int unsigned CTRL_ALU_SRC = 0;
   localparam int unsigned CTRL_ALU_OP  = 1;
   localparam int unsigned CTRL_BRANCH  = 3;
   localparam int unsigned CTRL_MEM_RD  = 4;
   localparam int unsigned CTRL_MEM_WR  = 5;
   localparam int unsigned CTRL_MEM2REG = 6;
   localparam int unsigned CTRL_REG_WR  = 7;
   localparam int unsigned CTRL_MUL     = 8;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/exec_stage_if.sv
// Decode-to-EX and EX-to-memory signal bundle; slave is the EX stage, master drives decode side.
interface exec_stage_if #(parameter int XLEN = 64);
   import exec_pkg::*;

   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_imm;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [4:0]      id_rd;
   ctrl_t           id_ctrl;
   logic [3:0]      id_func;
   logic            hold;
   logic            flush;
   logic [4:0]      fm_rd;
   logic [XLEN-1:0] fm_data;
   logic [4:0]      fw_rd;
   logic [XLEN-1:0] fw_data;

   logic            ex_stall;
   logic            ex_valid;
   ctrl_t           ex_ctrl;
   logic [4:0]      ex_rd;
   logic [XLEN-1:0] ex_result;
   logic [XLEN-1:0] ex_store_data;
   logic            br_taken;
   logic [XLEN-1:0] br_target;

   modport master (
      output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
             id_ctrl, id_func, hold, flush, fm_rd, fm_data, fw_rd, fw_data,
      input  ex_stall, ex_valid, ex_ctrl, ex_rd, ex_result, ex_store_data, br_taken, br_target
   );

   modport slave (
      input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
             id_ctrl, id_func, hold, flush, fm_rd, fm_data, fw_rd, fw_data,
      output ex_stall, ex_valid, ex_ctrl, ex_rd, ex_result, ex_store_data, br_taken, br_target
   );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU with funct decode; alu_op selects fixed ADD/SUB or decode of {funct7[5], funct3}.
module exec_alu
   import exec_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  alu_op_e         op,
   input  logic [3:0]      func,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   localparam int SHW = $clog2(XLEN);

   alu_fn_e        fn;
   logic [SHW-1:0] shamt;

   assign shamt = b[SHW-1:0];

   // funct7[5] selects SUB only for register-register ops; for immediates it is imm data.
   always_comb begin
      fn = FN_ADD;
      case (op)
         ALU_ADD: fn = FN_ADD;
         ALU_SUB: fn = FN_SUB;
         default: begin
            case (func[2:0])
               3'b000:  fn = (op == ALU_FUNC && func[3]) ? FN_SUB : FN_ADD;
               3'b001:  fn = FN_SLL;
               3'b010:  fn = FN_SLT;
               3'b011:  fn = FN_SLTU;
               3'b100:  fn = FN_XOR;
               3'b101:  fn = func[3] ? FN_SRA : FN_SRL;
               3'b110:  fn = FN_OR;
               default: fn = FN_AND;
            endcase
         end
      endcase
   end

   always_comb begin
      result = '0;
      case (fn)
         FN_ADD:  result = a + b;
         FN_SUB:  result = a - b;
         FN_AND:  result = a & b;
         FN_OR:   result = a | b;
         FN_XOR:  result = a ^ b;
         FN_SLL:  result = a << shamt;
         FN_SRL:  result = a >> shamt;
         FN_SRA:  result = $signed(a) >>> shamt;
         FN_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         FN_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/exec_stage.sv
// EX stage: ID/EX register, operand forwarding, ALU, branch resolve and a shift-add multiplier.
module exec_stage
   import exec_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int BR_SHIFT = 1,
   parameter int MUL_EN   = 1
) (
   input logic          clk,
   input logic          rst,
   exec_stage_if.slave  bus
);

   localparam int  CNT_W  = $clog2(XLEN);
   localparam bit  MUL_ON = (MUL_EN != 0);

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;
   ctrl_t           r_ctrl;
   logic [3:0]      r_func;

   mul_state_e      state;
   logic [XLEN-1:0] mul_a;
   logic [XLEN-1:0] mul_b;
   logic [XLEN-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] raw_result;
   alu_op_e         alu_op;
   logic            is_mul;
   logic            mul_req;
   logic            stall;
   logic            valid_out;
   logic            load;

   // EX/MEM is the younger producer, so it is checked first.
   always_comb begin
      rs1_fwd = r_rs1_data;
      if (r_rs1 != 5'd0 && r_rs1 == bus.fm_rd)      rs1_fwd = bus.fm_data;
      else if (r_rs1 != 5'd0 && r_rs1 == bus.fw_rd) rs1_fwd = bus.fw_data;
      rs2_fwd = r_rs2_data;
      if (r_rs2 != 5'd0 && r_rs2 == bus.fm_rd)      rs2_fwd = bus.fm_data;
      else if (r_rs2 != 5'd0 && r_rs2 == bus.fw_rd) rs2_fwd = bus.fw_data;
   end

   assign is_mul  = r_ctrl.mul && MUL_ON;
   assign mul_req = r_valid && is_mul;
   assign stall   = (state == MUL_IDLE && mul_req) || (state == MUL_BUSY);
   assign valid_out = r_valid && (!is_mul || state == MUL_DONE);
   assign load    = !bus.hold && !stall;
   assign alu_b   = r_ctrl.alu_src ? r_imm : rs2_fwd;
   assign alu_op  = r_ctrl.mul ? ALU_ADD : r_ctrl.alu_op;

   exec_alu #(.XLEN(XLEN)) u_alu (
      .op     (alu_op),
      .func   (r_func),
      .a      (rs1_fwd),
      .b      (alu_b),
      .result (alu_res)
   );

   assign raw_result = is_mul ? acc : alu_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_imm      <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_ctrl     <= '0;
         r_func     <= '0;
         state      <= MUL_IDLE;
         mul_a      <= '0;
         mul_b      <= '0;
         acc        <= '0;
         cnt        <= '0;
      end else begin
         if (load) begin
            r_pc       <= bus.id_pc;
            r_imm      <= bus.id_imm;
            r_rs1_data <= bus.id_rs1_data;
            r_rs2_data <= bus.id_rs2_data;
            r_rs1      <= bus.id_rs1;
            r_rs2      <= bus.id_rs2;
            r_rd       <= bus.id_rd;
            r_ctrl     <= bus.id_ctrl;
            r_func     <= bus.id_func;
         end
         // Flush overrides hold: valid and FSM drop even while the rest of EX is frozen.
         if (bus.flush) begin
            r_valid <= 1'b0;
            state   <= MUL_IDLE;
         end else if (!bus.hold) begin
            if (!stall) r_valid <= bus.id_valid;
            case (state)
               MUL_IDLE: begin
                  if (mul_req) begin
                     state <= MUL_BUSY;
                     mul_a <= rs1_fwd;
                     mul_b <= rs2_fwd;
                     acc   <= '0;
                     cnt   <= '0;
                  end
               end
               MUL_BUSY: begin
                  if (mul_b[0]) acc <= acc + mul_a;
                  mul_a <= mul_a << 1;
                  mul_b <= mul_b >> 1;
                  cnt   <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN-1)) state <= MUL_DONE;
               end
               default: state <= MUL_IDLE;
            endcase
         end
      end
   end

   assign bus.ex_stall      = stall;
   assign bus.ex_valid      = valid_out;
   assign bus.ex_ctrl       = valid_out ? r_ctrl : '0;
   assign bus.ex_rd         = valid_out ? r_rd : '0;
   assign bus.ex_result     = valid_out ? raw_result : '0;
   assign bus.ex_store_data = valid_out ? rs2_fwd : '0;
   assign bus.br_taken      = valid_out && r_ctrl.branch && (raw_result == '0);
   assign bus.br_target     = valid_out ? (r_pc + (r_imm << BR_SHIFT)) : '0;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: 64-bit and 32-bit instances, directed vectors.
module tb_exec_stage;
   import exec_pkg::*;

   typedef struct packed {
      logic [63:0] result;
      logic [63:0] store;
      logic [63:0] target;
      ctrl_t       ctrl;
      logic [4:0]  rd;
      logic        taken;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t  q64[$];
   string n64[$];
   exp_t  q32[$];
   string n32[$];

   exec_stage_if #(.XLEN(64)) bus64 ();
   exec_stage_if #(.XLEN(32)) bus32 ();

   exec_stage #(.XLEN(64), .BR_SHIFT(1), .MUL_EN(1)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
   exec_stage #(.XLEN(32), .BR_SHIFT(1), .MUL_EN(1)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic ctrl_t mk_ctrl(input logic src, input alu_op_e op, input logic br,
                                     input logic wr, input logic mul);
      ctrl_t c;
      c = '0;
      c.alu_src = src;
      c.alu_op  = op;
      c.branch  = br;
      c.reg_wr  = wr;
      c.mul     = mul;
      return c;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Monitor: pops one expectation per consumed (valid, not held) result.
   initial begin
      exp_t e;
      string nm;
      forever begin
         @(negedge clk);
         if (bus64.ex_valid && !bus64.hold) begin
            n_checks++;
            if (q64.size() == 0) begin
               n_fail++;
               $display("FAIL sb64_unexpected result=%h expected=none", bus64.ex_result);
            end else begin
               e  = q64.pop_front();
               nm = n64.pop_front();
               if (bus64.ex_result !== e.result || bus64.ex_store_data !== e.store ||
                   bus64.br_target !== e.target || bus64.ex_ctrl !== e.ctrl ||
                   bus64.ex_rd !== e.rd || bus64.br_taken !== e.taken) begin
                  n_fail++;
                  $display("FAIL %s result=%h/%h store=%h/%h target=%h/%h ctrl=%h/%h rd=%0d/%0d taken=%b/%b (actual/expected)",
                           nm, bus64.ex_result, e.result, bus64.ex_store_data, e.store,
                           bus64.br_target, e.target, bus64.ex_ctrl, e.ctrl,
                           bus64.ex_rd, e.rd, bus64.br_taken, e.taken);
               end
            end
         end
      end
   end

   initial begin
      exp_t e;
      string nm;
      forever begin
         @(negedge clk);
         if (bus32.ex_valid && !bus32.hold) begin
            n_checks++;
            if (q32.size() == 0) begin
               n_fail++;
               $display("FAIL sb32_unexpected result=%h expected=none", bus32.ex_result);
            end else begin
               e  = q32.pop_front();
               nm = n32.pop_front();
               if (64'(bus32.ex_result) !== e.result || 64'(bus32.br_target) !== e.target ||
                   bus32.ex_rd !== e.rd) begin
                  n_fail++;
                  $display("FAIL %s result=%h/%h target=%h/%h rd=%0d/%0d (actual/expected)",
                           nm, bus32.ex_result, e.result, bus32.br_target, e.target,
                           bus32.ex_rd, e.rd);
               end
            end
         end
      end
   end

   task automatic drive64(input ctrl_t c, input logic [3:0] f, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2);
      bus64.id_ctrl = c;  bus64.id_func = f;  bus64.id_pc = pc;  bus64.id_imm = imm;
      bus64.id_rs1 = rs1; bus64.id_rs2 = rs2; bus64.id_rd = rd;
      bus64.id_rs1_data = d1; bus64.id_rs2_data = d2;
      bus64.id_valid = 1'b1;
      @(posedge clk); #1;
      bus64.id_valid = 1'b0;
   endtask

   task automatic alu64(input string nm, input ctrl_t c, input logic [3:0] f,
                        input logic [63:0] pc, input logic [63:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] res, input logic [63:0] st, input logic tk);
      exp_t e;
      e.result = res; e.store = st; e.target = pc + (imm << 1);
      e.ctrl = c; e.rd = rd; e.taken = tk;
      q64.push_back(e); n64.push_back(nm);
      drive64(c, f, pc, imm, rs1, rs2, rd, d1, d2);
      @(posedge clk); #1;
      bus64.fm_rd = '0; bus64.fw_rd = '0; bus64.fm_data = '0; bus64.fw_data = '0;
   endtask

   // Issues a MUL and counts negedges with ex_stall high; optional 4-cycle hold at count hold_at.
   task automatic run_mul(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] prod, input int hold_at, output int n,
                          output int vwhile);
      exp_t e;
      bit done;
      ctrl_t m;
      m = mk_ctrl(1'b0, ALU_FUNC, 1'b0, 1'b1, 1'b1);
      e.result = prod; e.store = b; e.target = 64'h200; e.ctrl = m; e.rd = 5'd7; e.taken = 1'b0;
      q64.push_back(e); n64.push_back(nm);
      drive64(m, 4'b0000, 64'h200, 64'h0, 5'd10, 5'd11, 5'd7, a, b);
      n = 0; vwhile = 0; done = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         if (!bus64.ex_stall) done = 1;
         else begin
            if (bus64.ex_valid) vwhile++;
            n++;
            if (n == hold_at)     bus64.hold = 1'b1;
            if (n == hold_at + 4) bus64.hold = 1'b0;
         end
      end
      bus64.hold = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drive32(input string nm, input ctrl_t c, input logic [3:0] f,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] res, input int wait_cycles);
      exp_t e;
      e = '0;
      e.result = 64'(res); e.target = 64'h80; e.rd = 5'd3; e.ctrl = c;
      q32.push_back(e); n32.push_back(nm);
      bus32.id_ctrl = c; bus32.id_func = f; bus32.id_pc = 32'h80; bus32.id_imm = '0;
      bus32.id_rs1 = 5'd1; bus32.id_rs2 = 5'd2; bus32.id_rd = 5'd3;
      bus32.id_rs1_data = d1; bus32.id_rs2_data = d2;
      bus32.id_valid = 1'b1;
      @(posedge clk); #1;
      bus32.id_valid = 1'b0;
      repeat (wait_cycles) @(posedge clk);
      #1;
   endtask

   ctrl_t c_r, c_i, c_b, c_sw;
   int    n, v, vcnt, scnt;

   initial begin
      bus64.id_valid = 0; bus64.id_pc = '0; bus64.id_imm = '0; bus64.id_rs1_data = '0;
      bus64.id_rs2_data = '0; bus64.id_rs1 = '0; bus64.id_rs2 = '0; bus64.id_rd = '0;
      bus64.id_ctrl = '0; bus64.id_func = '0; bus64.hold = 0; bus64.flush = 0;
      bus64.fm_rd = '0; bus64.fm_data = '0; bus64.fw_rd = '0; bus64.fw_data = '0;
      bus32.id_valid = 0; bus32.id_pc = '0; bus32.id_imm = '0; bus32.id_rs1_data = '0;
      bus32.id_rs2_data = '0; bus32.id_rs1 = '0; bus32.id_rs2 = '0; bus32.id_rd = '0;
      bus32.id_ctrl = '0; bus32.id_func = '0; bus32.hold = 0; bus32.flush = 0;
      bus32.fm_rd = '0; bus32.fm_data = '0; bus32.fw_rd = '0; bus32.fw_data = '0;
      c_r  = mk_ctrl(1'b0, ALU_FUNC, 1'b0, 1'b1, 1'b0);
      c_i  = mk_ctrl(1'b1, ALU_IMM,  1'b0, 1'b1, 1'b0);
      c_b  = mk_ctrl(1'b0, ALU_SUB,  1'b1, 1'b0, 1'b0);
      c_sw = mk_ctrl(1'b1, ALU_ADD,  1'b0, 1'b0, 1'b0);
      c_sw.mem_wr = 1'b1;

      #12;
      check("rst_valid",  64'(bus64.ex_valid), 64'd0);
      check("rst_stall",  64'(bus64.ex_stall), 64'd0);
      check("rst_result", bus64.ex_result, 64'd0);
      check("rst_target", bus64.br_target, 64'd0);
      check("rst_ctrl",   64'(bus64.ex_ctrl), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      alu64("addi", c_i, 4'b0000, 64'h40, 64'hFFFF_FFFF_FFFF_FFFD, 5'd2, 5'd0, 5'd1,
            64'd5, 64'd0, 64'd2, 64'd0, 1'b0);
      bus64.fm_rd = 5'd3; bus64.fm_data = 64'd7; bus64.fw_rd = 5'd3; bus64.fw_data = 64'd9;
      alu64("sub_fwd_both", c_r, 4'b1000, 64'h44, 64'h0, 5'd3, 5'd4, 5'd5,
            64'd100, 64'd2, 64'd5, 64'd2, 1'b0);
      bus64.fw_rd = 5'd3; bus64.fw_data = 64'd9;
      alu64("add_fwd_wb", c_r, 4'b0000, 64'h48, 64'h0, 5'd3, 5'd4, 5'd5,
            64'd100, 64'd2, 64'd11, 64'd2, 1'b0);
      bus64.fm_rd = 5'd4; bus64.fm_data = 64'h20; bus64.fw_rd = 5'd4; bus64.fw_data = 64'h40;
      alu64("or_fwd_rs2", c_r, 4'b0110, 64'h4C, 64'h0, 5'd1, 5'd4, 5'd6,
            64'd1, 64'd2, 64'h21, 64'h20, 1'b0);
      bus64.fm_rd = 5'd0; bus64.fm_data = 64'h55;
      alu64("x0_no_fwd", c_i, 4'b0000, 64'h50, 64'h1, 5'd0, 5'd0, 5'd6,
            64'd0, 64'd0, 64'd1, 64'd0, 1'b0);
      alu64("sll_mask", c_r, 4'b0001, 64'h54, 64'h0, 5'd6, 5'd7, 5'd8,
            64'd1, 64'h41, 64'd2, 64'h41, 1'b0);
      alu64("sra", c_r, 4'b1101, 64'h58, 64'h0, 5'd6, 5'd7, 5'd8,
            64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 64'd4, 1'b0);
      alu64("srl", c_r, 4'b0101, 64'h5C, 64'h0, 5'd6, 5'd7, 5'd8,
            64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 64'd4, 1'b0);
      alu64("slt", c_r, 4'b0010, 64'h60, 64'h0, 5'd6, 5'd7, 5'd8,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 64'd1, 1'b0);
      alu64("sltu", c_r, 4'b0011, 64'h64, 64'h0, 5'd6, 5'd7, 5'd8,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd1, 1'b0);
      alu64("xor", c_r, 4'b0100, 64'h68, 64'h0, 5'd6, 5'd7, 5'd8,
            64'hF0, 64'hFF, 64'h0F, 64'hFF, 1'b0);
      alu64("and", c_r, 4'b0111, 64'h6C, 64'h0, 5'd6, 5'd7, 5'd8,
            64'hF0, 64'h3C, 64'h30, 64'h3C, 1'b0);
      alu64("add_wrap64", c_r, 4'b0000, 64'h70, 64'h0, 5'd6, 5'd7, 5'd8,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd1, 1'b0);
      bus64.fw_rd = 5'd9; bus64.fw_data = 64'hDEAD;
      alu64("sw_store_fwd", c_sw, 4'b0010, 64'h74, 64'h10, 5'd8, 5'd9, 5'd0,
            64'h1000, 64'd0, 64'h1010, 64'hDEAD, 1'b0);
      alu64("beq_taken", c_b, 4'b0000, 64'h100, 64'h8, 5'd1, 5'd2, 5'd0,
            64'h10, 64'h10, 64'd0, 64'h10, 1'b1);
      alu64("beq_not_taken", c_b, 4'b0000, 64'h100, 64'h8, 5'd1, 5'd2, 5'd0,
            64'h10, 64'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h11, 1'b0);

      run_mul("mul_ones_x3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, -10, n, v);
      check("mul_stall_cycles", 64'(n), 64'd65);
      check("mul_valid_while_stalled", 64'(v), 64'd0);

      run_mul("mul_hold", 64'h0123_4567, 64'h100, 64'h1_2345_6700, 20, n, v);
      check("mul_hold_stall_cycles", 64'(n), 64'd69);
      check("mul_hold_valid_while_stalled", 64'(v), 64'd0);

      drive64(mk_ctrl(1'b0, ALU_FUNC, 1'b0, 1'b1, 1'b1), 4'b0000, 64'h200, 64'h0,
              5'd10, 5'd11, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
      repeat (10) @(posedge clk);
      #1 bus64.flush = 1'b1;
      @(posedge clk); #1;
      bus64.flush = 1'b0;
      check("flush_stall", 64'(bus64.ex_stall), 64'd0);
      check("flush_valid", 64'(bus64.ex_valid), 64'd0);
      vcnt = 0; scnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus64.ex_valid) vcnt++;
         if (bus64.ex_stall) scnt++;
      end
      check("flush_valid_never", 64'(vcnt), 64'd0);
      check("flush_stall_never", 64'(scnt), 64'd0);

      @(posedge clk); #1;
      drive64(mk_ctrl(1'b0, ALU_FUNC, 1'b0, 1'b1, 1'b1), 4'b0000, 64'h200, 64'h0,
              5'd10, 5'd11, 5'd7, 64'd5, 64'd6);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_stall",  64'(bus64.ex_stall), 64'd0);
      check("arst_valid",  64'(bus64.ex_valid), 64'd0);
      check("arst_result", bus64.ex_result, 64'd0);
      check("arst_target", bus64.br_target, 64'd0);
      check("arst_store",  bus64.ex_store_data, 64'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("arst_stall_after", 64'(bus64.ex_stall), 64'd0);
      @(posedge clk); #1;

      drive32("add_wrap32", c_r, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 2);
      drive32("sra32_mask", c_r, 4'b1101, 32'h8000_0000, 32'h21, 32'hC000_0000, 2);
      drive32("mul32", mk_ctrl(1'b0, ALU_FUNC, 1'b0, 1'b1, 1'b1), 4'b0000,
              32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 40);

      repeat (5) @(posedge clk);
      check("sb64_drain", 64'(q64.size()), 64'd0);
      check("sb32_drain", 64'(q32.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
